// File: rtl/emmc_cmd_seq.sv
// eMMC CMD-line sequencer: 48-bit command out with CRC7, R1/R2/R3 response in and checked.
// Optional EMMC_CMD_ABORT_EN adds abort_i / err_abort_o.
module emmc_cmd_seq #(
  parameter int NCR_MAX = 64,
  parameter int NCC     = 8
) (
  input  logic         clk_i,
  input  logic         nrst_i,
  input  logic         tick_i,
  input  logic         start_i,
  input  logic [5:0]   cmd_idx_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [1:0]   resp_type_i,
`ifdef EMMC_CMD_ABORT_EN
  input  logic         abort_i,
  output logic         err_abort_o,
`endif
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] resp_o,
  output logic         err_timeout_o,
  output logic         err_crc_o,
  output logic         err_end_o,
  output logic         cmd_o,
  output logic         cmd_oe_o,
  input  logic         cmd_i
);

  typedef enum logic [2:0] {IDLE, TX, WAIT_RESP, RX, GAP} state_t;

  localparam logic [7:0] NCR_L = 8'(NCR_MAX);
  localparam logic [7:0] NCC_L = 8'(NCC);

  // CRC7 (x^7+x^3+1) over the low n bits of d, MSB first
  function automatic logic [6:0] crc7(input logic [119:0] d, input int n);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      if (i < n) begin
        fb = d[i] ^ c[6];
        c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
    end
    return c;
  endfunction

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [47:0]    frame_q, frame_d;
  logic [126:0]   sh_q, sh_d;
  logic [127:0]   resp_q, resp_d, sh_nxt, r1_resp;
  logic [1:0]     type_q, type_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic           eto_q, eto_d, ecrc_q, ecrc_d, eend_q, eend_d;
  logic           cmd_q, cmd_d, oe_q, oe_d;
  logic [7:0]     rx_len;
  logic [6:0]     rx_crc;
`ifdef EMMC_CMD_ABORT_EN
  logic           eab_q, eab_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    sh_d    = sh_q;
    resp_d  = resp_q;
    type_d  = type_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    eto_d   = eto_q;
    ecrc_d  = ecrc_q;
    eend_d  = eend_q;
    cmd_d   = cmd_q;
    oe_d    = oe_q;
`ifdef EMMC_CMD_ABORT_EN
    eab_d   = eab_q;
`endif
    // Start bit is already in sh_q when RX begins, so bit counts include it
    sh_nxt  = {sh_q, cmd_i};
    r1_resp = {90'b0, sh_nxt[45:8]};
    rx_len  = (type_q == 2'b10) ? 8'd136 : 8'd48;
    rx_crc  = (type_q == 2'b10) ? crc7(sh_nxt[127:8], 120)
                                : crc7({80'b0, sh_nxt[47:8]}, 40);
    unique case (state_q)
      IDLE: begin
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (start_i) begin
          frame_d = {2'b01, cmd_idx_i, cmd_arg_i,
                     crc7({80'b0, 2'b01, cmd_idx_i, cmd_arg_i}, 40), 1'b1};
          type_d  = resp_type_i;
          resp_d  = '0;
          sh_d    = '0;
          eto_d   = 1'b0;
          ecrc_d  = 1'b0;
          eend_d  = 1'b0;
`ifdef EMMC_CMD_ABORT_EN
          eab_d   = 1'b0;
`endif
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = TX;
        end
      end
      TX: if (tick_i) begin
        cmd_d   = frame_q[47];
        oe_d    = 1'b1;
        frame_d = {frame_q[46:0], 1'b0};
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == 8'd47) begin
          cnt_d   = '0;
          state_d = (type_q == 2'b00) ? GAP : WAIT_RESP;
        end
      end
      WAIT_RESP: if (tick_i) begin
        oe_d  = 1'b0;
        cmd_d = 1'b1;
        if (!cmd_i) begin
          sh_d    = sh_nxt[126:0];
          cnt_d   = 8'd1;
          state_d = RX;
        end else if (cnt_q + 8'd1 == NCR_L) begin
          eto_d   = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RX: if (tick_i) begin
        sh_d  = sh_nxt[126:0];
        cnt_d = cnt_q + 8'd1;
        if (cnt_q + 8'd1 == rx_len) begin
          resp_d  = (type_q == 2'b10) ? sh_nxt : r1_resp;
          ecrc_d  = (type_q != 2'b11) && (rx_crc != sh_nxt[7:1]);
          eend_d  = !sh_nxt[0];
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: if (tick_i) begin
        oe_d  = 1'b0;
        cmd_d = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q + 8'd1 == NCC_L) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef EMMC_CMD_ABORT_EN
    if (abort_i && busy_q && state_q != IDLE && state_q != GAP) begin
      state_d = GAP;
      cnt_d   = '0;
      oe_d    = 1'b0;
      cmd_d   = 1'b1;
      eab_d   = 1'b1;
      resp_d  = {1'b0, sh_q};
    end
`endif
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      sh_q    <= '0;
      resp_q  <= '0;
      type_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eto_q   <= 1'b0;
      ecrc_q  <= 1'b0;
      eend_q  <= 1'b0;
      cmd_q   <= 1'b1;
      oe_q    <= 1'b0;
`ifdef EMMC_CMD_ABORT_EN
      eab_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      sh_q    <= sh_d;
      resp_q  <= resp_d;
      type_q  <= type_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eto_q   <= eto_d;
      ecrc_q  <= ecrc_d;
      eend_q  <= eend_d;
      cmd_q   <= cmd_d;
      oe_q    <= oe_d;
`ifdef EMMC_CMD_ABORT_EN
      eab_q   <= eab_d;
`endif
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign resp_o        = resp_q;
  assign err_timeout_o = eto_q;
  assign err_crc_o     = ecrc_q;
  assign err_end_o     = eend_q;
  assign cmd_o         = cmd_q;
  assign cmd_oe_o      = oe_q;
`ifdef EMMC_CMD_ABORT_EN
  assign err_abort_o   = eab_q;
`endif

endmodule

// File: tb/tb_emmc_cmd_seq.sv
// Scoreboard bench for emmc_cmd_seq: card model answers on cmd_i, results checked at done_o.
module tb_emmc_cmd_seq;
  logic         clk = 1'b0, nrst = 1'b0, tick = 1'b0, start = 1'b0, cmd_in = 1'b1;
  logic [5:0]   idx = '0;
  logic [31:0]  arg = '0;
  logic [1:0]   rtype = '0;
  logic         busy, done, eto, ecrc, eend, cmd_o, cmd_oe;
  logic [127:0] resp;

  emmc_cmd_seq dut (
    .clk_i(clk), .nrst_i(nrst), .tick_i(tick), .start_i(start),
    .cmd_idx_i(idx), .cmd_arg_i(arg), .resp_type_i(rtype),
    .busy_o(busy), .done_o(done), .resp_o(resp),
    .err_timeout_o(eto), .err_crc_o(ecrc), .err_end_o(eend),
    .cmd_o(cmd_o), .cmd_oe_o(cmd_oe), .cmd_i(cmd_in)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7m(input logic [119:0] d, input int n);
    logic [6:0] r;
    logic       b;
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      b = d[i] ^ r[6];
      r = {r[5:3], r[2] ^ b, r[1:0], b};
    end
    return r;
  endfunction

  // tick for the next edge is decided 2ns after each edge
  int divcnt = 0;
  bit tick_en = 1'b1;
  always @(posedge clk) begin
    #2;
    divcnt++;
    tick = tick_en && (divcnt % 4 == 0);
  end

  typedef struct {
    logic [47:0]  frame;
    logic [127:0] resp;
    logic         eto, ecrc, eend;
    int           lat;
  } exp_t;
  exp_t sb[$];

  logic [47:0]  cap;
  logic [135:0] card_bits;
  int oe_ticks = 0, tick_num = 0, start_tick = 0;
  int card_cnt = 0, card_idx = 0, card_dly = 0, card_len = 0;
  bit card_on = 1'b0, prev_done = 1'b0;

  always @(posedge clk) begin
    bit   t;
    exp_t e;
    t = tick;
    #1;
    if (prev_done) begin
      check("busy_after_done", 128'(busy), 128'(0));
      prev_done = 1'b0;
    end
    if (t) begin
      tick_num++;
      if (cmd_oe) begin
        cap = {cap[46:0], cmd_o};
        oe_ticks++;
        if (oe_ticks == 48) begin card_on = 1'b1; card_cnt = 0; end
      end else if (card_on) begin
        card_cnt++;
        if (card_cnt >= card_dly && card_idx < card_len) begin
          cmd_in = card_bits[card_len - 1 - card_idx];
          card_idx++;
        end else cmd_in = 1'b1;
      end
    end
    if (done) begin
      if (sb.size() == 0) check("sb_underflow", 128'(1), 128'(0));
      else begin
        e = sb.pop_front();
        check("frame", 128'(cap), 128'(e.frame));
        check("oe_ticks", 128'(oe_ticks), 128'(48));
        check("resp", resp, e.resp);
        check("err_timeout", 128'(eto), 128'(e.eto));
        check("err_crc", 128'(ecrc), 128'(e.ecrc));
        check("err_end", 128'(eend), 128'(e.eend));
        check("latency", 128'(tick_num - start_tick), 128'(e.lat));
      end
      check("busy_at_done", 128'(busy), 128'(1));
      prev_done = 1'b1;
    end
  end

  task automatic run(input logic [5:0] i, input logic [31:0] a, input logic [1:0] ty,
                     input logic [135:0] cb, input int cl, input int cd,
                     input logic [127:0] er, input logic et, input logic ec, input logic ee,
                     input int lat);
    exp_t e;
    @(negedge clk);
    while (tick) @(negedge clk);
    idx = i; arg = a; rtype = ty; start = 1'b1;
    cap = '0; oe_ticks = 0; card_on = 1'b0; card_cnt = 0; card_idx = 0;
    card_bits = cb; card_len = cl; card_dly = cd; cmd_in = 1'b1;
    e.frame = {2'b01, i, a, crc7m({80'b0, 2'b01, i, a}, 40), 1'b1};
    e.resp = er; e.eto = et; e.ecrc = ec; e.eend = ee; e.lat = lat;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    start_tick = tick_num;
    check("busy_after_accept", 128'(busy), 128'(1));
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 4000 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      check("done_wait_expired", 128'(sb.size()), 128'(0));
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [47:0] r1(input logic [5:0] i, input logic [31:0] st);
    return {2'b00, i, st, crc7m({80'b0, 2'b00, i, st}, 40), 1'b1};
  endfunction

  logic [47:0]  rb;
  logic [127:0] tmp;
  logic [119:0] cid;
  logic [6:0]   ccrc;

  initial begin
    #23;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_resp", resp, 128'(0));
    check("rst_errs", 128'({eto, ecrc, eend}), 128'(0));
    check("rst_cmd", 128'(cmd_o), 128'(1));
    check("rst_oe", 128'(cmd_oe), 128'(0));
    @(negedge clk); nrst = 1'b1;

    run(6'd0, 32'h0, 2'b00, '0, 0, 1, '0, 0, 0, 0, 56);
    wait_idle();
    check("cmd0_serial", 128'(cap), 128'(48'h400000000095));

    rb = r1(6'd17, 32'h00000900);
    run(6'd17, 32'h0, 2'b01, {88'b0, rb}, 48, 4, {90'b0, 6'd17, 32'h00000900}, 0, 0, 0, 108);
    wait_idle();
    check("cmd17_serial", 128'(cap), 128'(48'h510000000055));

    rb = r1(6'd17, 32'h00000900) ^ (48'h1 << 8);
    run(6'd17, 32'h0, 2'b01, {88'b0, rb}, 48, 4, {90'b0, 6'd17, 32'h00000901}, 0, 1, 0, 108);
    wait_idle();

    rb = r1(6'd13, 32'h12345678) & ~48'h1;
    run(6'd13, 32'hA5A50000, 2'b01, {88'b0, rb}, 48, 4, {90'b0, 6'd13, 32'h12345678}, 0, 0, 1, 108);
    wait_idle();

    run(6'd17, 32'h0, 2'b01, '0, 0, 1, '0, 1, 0, 0, 120);
    wait_idle();

    rb = r1(6'd7, 32'hCAFEF00D);
    run(6'd7, 32'h00010000, 2'b01, {88'b0, rb}, 48, 63, {90'b0, 6'd7, 32'hCAFEF00D}, 0, 0, 0, 167);
    wait_idle();
    run(6'd7, 32'h00010000, 2'b01, {88'b0, rb}, 48, 64, '0, 1, 0, 0, 120);
    wait_idle();

    rb = {2'b00, 6'h3F, 32'h00FF8080, 7'h7F, 1'b1};
    run(6'd1, 32'h40FF8080, 2'b11, {88'b0, rb}, 48, 4, {90'b0, 6'h3F, 32'h00FF8080}, 0, 0, 0, 108);
    wait_idle();

    tmp  = {$urandom, $urandom, $urandom, $urandom};
    cid  = tmp[119:0];
    ccrc = crc7m(cid, 120);
    run(6'd2, 32'h0, 2'b10, {2'b00, 6'h3F, cid, ccrc, 1'b1}, 136, 4,
        {cid, ccrc, 1'b1}, 0, 0, 0, 196);
    wait_idle();

    run(6'd55, 32'h0000FFFF, 2'b00, '0, 0, 1, '0, 0, 0, 0, 56);
    repeat (60) @(negedge clk);
    tick_en = 1'b0;
    repeat (40) @(negedge clk);
    check("freeze_oe", 128'(cmd_oe), 128'(1));
    check("freeze_cmd", 128'(cmd_o), 128'(sb[0].frame[48 - oe_ticks]));
    repeat (40) @(negedge clk);
    check("freeze_cmd_hold", 128'(cmd_o), 128'(sb[0].frame[48 - oe_ticks]));
    tick_en = 1'b1;
    wait_idle();

    run(6'd0, 32'hFFFFFFFF, 2'b00, '0, 0, 1, '0, 0, 0, 0, 56);
    repeat (60) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("arst_oe", 128'(cmd_oe), 128'(0));
    check("arst_busy", 128'(busy), 128'(0));
    check("arst_cmd", 128'(cmd_o), 128'(1));
    sb.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    rb = r1(6'd17, 32'h00000900);
    run(6'd17, 32'h0, 2'b01, {88'b0, rb}, 48, 4, {90'b0, 6'd17, 32'h00000900}, 0, 0, 0, 108);
    wait_idle();
    check("post_rst_serial", 128'(cap), 128'(48'h510000000055));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
